// File: rtl/pwm_generator.sv
// Single-channel PWM generator with a free-running period counter.
// Optional one-clock period strobe on `wrap` when PWM_WRAP_STROBE_EN is defined.
module pwm_generator #(
    parameter int XLEN = 3
) (
    input  logic            rst,
    input  logic            clk,
    input  logic [XLEN-1:0] ampl,
    input  logic [XLEN:0]   duty,
    output logic            signal
`ifdef PWM_WRAP_STROBE_EN
    ,
    output logic            wrap
`endif
);

    localparam logic [XLEN+1:0] ONE = {{(XLEN+1){1'b0}}, 1'b1};

    logic [XLEN:0]   cnt;
    logic [XLEN+1:0] cnt_inc;
    logic            reload;

    // One extra bit so cnt+1 at the top of the range still compares correctly
    assign cnt_inc = {1'b0, cnt} + ONE;
    assign reload  = (cnt_inc >= {1'b0, duty});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            signal <= 1'b0;
        end else begin
            signal <= (cnt < {1'b0, ampl});
            cnt    <= reload ? '0 : cnt_inc[XLEN:0];
        end
    end

`ifdef PWM_WRAP_STROBE_EN
    logic wrap_pend;

    // Delayed one clock so the strobe lines up with signal's first slot
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_pend <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            wrap_pend <= reload;
            wrap      <= wrap_pend;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed spec patterns plus random traffic.
// Checks wrap as well when built with PWM_WRAP_STROBE_EN.
module tb_pwm_generator;

    localparam int XLEN = 3;

    logic            rst  = 1'b1;
    logic            clk  = 1'b0;
    logic [XLEN-1:0] ampl = '0;
    logic [XLEN:0]   duty = '0;
    logic            signal;
`ifdef PWM_WRAP_STROBE_EN
    logic            wrap;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: position inside the current period, and whether the
    // previous edge started a new period (strobe shows one clock later).
    int pos       = 0;
    bit new_per   = 0;
    bit exp_sig   = 0;
    bit exp_wrap  = 0;

    pwm_generator #(.XLEN(XLEN)) dut (
        .rst    (rst),
        .clk    (clk),
        .ampl   (ampl),
        .duty   (duty),
        .signal (signal)
`ifdef PWM_WRAP_STROBE_EN
        ,
        .wrap   (wrap)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock; lit < 0 means no literal expectation from the spec table.
    task automatic tick(input bit r, input int a, input int d, input int lit);
        rst  = r;
        ampl = a[XLEN-1:0];
        duty = d[XLEN:0];
        @(posedge clk);
        #1;
        if (r) begin
            pos      = 0;
            new_per  = 0;
            exp_sig  = 0;
            exp_wrap = 0;
        end else begin
            exp_sig  = (pos < a);
            exp_wrap = new_per;
            if (pos + 1 < d) begin
                pos++;
                new_per = 0;
            end else begin
                pos     = 0;
                new_per = 1;
            end
        end
        check("signal_model", signal, exp_sig);
`ifdef PWM_WRAP_STROBE_EN
        check("wrap_model", wrap, exp_wrap);
`endif
        if (lit >= 0)
            check("signal_pattern", signal, lit[0]);
    endtask

    task automatic run_pattern(input int a, input int d, input string pat);
        for (int i = 0; i < pat.len(); i++)
            tick(0, a, d, (pat[i] == "1") ? 1 : 0);
    endtask

    initial begin
        int a, d;

        // reset state
        tick(1, 0, 0, 0);
        tick(1, 5, 7, 0);

        // 1: ampl=0 never high
        run_pattern(0, 7, "000000000");

        // 2: ampl>=duty never low
        tick(1, 7, 7, 0);
        run_pattern(7, 7, "111111111");

        // 3: 1111000 x3, wrap on clocks 8 and 15
        tick(1, 4, 7, 0);
        for (int i = 1; i <= 21; i++) begin
            tick(0, 4, 7, ((i - 1) % 7 < 4) ? 1 : 0);
`ifdef PWM_WRAP_STROBE_EN
            check("wrap_pattern", wrap, (i == 8 || i == 15) ? 1'b1 : 1'b0);
`endif
        end

        // 4: 110110110 then duty=0 holds high
        tick(1, 2, 3, 0);
        run_pattern(2, 3, "110110110");
        run_pattern(2, 0, "11111");
        run_pattern(2, 1, "111");
        run_pattern(0, 1, "000");

        // 5: duty lowered below cnt+1 wraps on next edge
        tick(1, 4, 15, 0);
        run_pattern(4, 15, "1111000000");
        run_pattern(4, 5, "0");
        run_pattern(4, 5, "1111011110");

        // 6: reset mid-period
        tick(1, 3, 7, 0);
        run_pattern(3, 7, "11");
        tick(1, 3, 7, 0);
        run_pattern(3, 7, "11100001110000");

        // random traffic against the model
        a = 3;
        d = 7;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 7);
            if ($urandom_range(0, 11) == 0) d = $urandom_range(0, 15);
            tick(($urandom_range(0, 49) == 0), a, d, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
